alu_exec_unit: RTL and testbench

Registered execute stage for the 64-bit single-cycle RISC-V datapath. It decodes the main-control `alu_op` plus `funct7`/`funct3` into a 4-bit ALU operation and runs the 64-bit ALU. It also forms the branch-taken select as `branch AND zero`. All outputs are registered on `clk` and feed the data-memory address, the write-back mux and the PC-source mux.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_decoder.sv | 40 ++++
 rtl/alu_exec_unit.sv | 104 ++++++++++
 tb/tb_alu_exec_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the execute stage: alu_op, ALU operation codes, funct3.
package alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ADD    = 2'b11
  } alu_op_e;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational alu_op/funct7/funct3 to ALU operation decode.
// ALU_SHIFT_EN: decode SLL/SRL/SRA; otherwise funct3 001/101 fall back to ADD.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] alu_ctrl
);

  // Only funct7[5] distinguishes SUB/SRA from ADD/SRL.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADD_SUB: alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
          F3_AND:     alu_ctrl = ALU_AND;
          F3_OR:      alu_ctrl = ALU_OR;
          F3_XOR:     alu_ctrl = ALU_XOR;
          F3_SLT:     alu_ctrl = ALU_SLT;
          F3_SLTU:    alu_ctrl = ALU_SLTU;
`ifdef ALU_SHIFT_EN
          F3_SLL:     alu_ctrl = ALU_SLL;
          F3_SR:      alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
`endif
          default:    alu_ctrl = ALU_ADD;
        endcase
      end
      default:      alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered execute stage: decode, 64-bit ALU, branch select.
// ALU_SHIFT_EN: include the SLL/SRL/SRA shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [6:0]       funct7,
  input  logic [2:0]       funct3,
  input  logic             branch,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH:0]   r,
  output logic             pc_src
);

  logic [3:0]       ctrl_next;
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] result_next;
  logic             ovf_next;
  logic [WIDTH:0]   r_next;
  logic             zero_next;

  alu_op_decoder u_decoder (
    .alu_op   (alu_op),
    .funct7   (funct7),
    .funct3   (funct3),
    .alu_ctrl (ctrl_next)
  );

  // One adder serves ADD and SUB; SUB inverts input2 and injects the +1 as carry-in.
  assign is_sub   = (ctrl_next == ALU_SUB);
  assign b_op     = is_sub ? ~input2 : input2;
  assign add_full = {1'b0, input1} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  assign sum      = add_full[WIDTH-1:0];
  assign add_ovf  = (input1[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);

`ifdef ALU_SHIFT_EN
  logic [5:0] shamt;
  assign shamt = input2[5:0];
`endif

  always_comb begin
    result_next = '0;
    ovf_next    = 1'b0;
    case (ctrl_next)
      ALU_AND:  result_next = input1 & input2;
      ALU_OR:   result_next = input1 | input2;
      ALU_XOR:  result_next = input1 ^ input2;
      ALU_ADD,
      ALU_SUB: begin
        result_next = sum;
        ovf_next    = add_ovf;
      end
      ALU_SLT:  result_next = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      ALU_SLTU: result_next = {{(WIDTH-1){1'b0}}, (input1 < input2)};
`ifdef ALU_SHIFT_EN
      ALU_SLL:  result_next = input1 << shamt;
      ALU_SRL:  result_next = input1 >> shamt;
      ALU_SRA:  result_next = $signed(input1) >>> shamt;
`endif
      default:  result_next = '0;
    endcase
  end

  always_comb begin
    r_next = {1'b0, result_next};
    if (ctrl_next == ALU_ADD || ctrl_next == ALU_SUB) begin
      r_next = add_full;
    end
  end

  assign zero_next = (result_next == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_ctrl <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      r        <= '0;
      pc_src   <= 1'b0;
    end else begin
      alu_ctrl <= ctrl_next;
      result   <= result_next;
      zero     <= zero_next;
      overflow <= ovf_next;
      r        <= r_next;
      pc_src   <= branch & zero_next;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - table-driven scoreboard bench for alu_exec_unit (honours ALU_SHIFT_EN).
module tb_alu_exec_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   alu_op;
  logic [6:0]   funct7;
  logic [2:0]   funct3;
  logic         branch;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic [W:0]   r;
  logic         pc_src;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_op   (alu_op),
    .funct7   (funct7),
    .funct3   (funct3),
    .branch   (branch),
    .input1   (input1),
    .input2   (input2),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .r        (r),
    .pc_src   (pc_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   ctrl;
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic [W:0]   r;
    logic         pc_src;
  } out_t;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [6:0]   f7;
    logic [2:0]   f3;
    logic         br;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ctrl;
    logic [W-1:0] res;
    logic         ovf;
    logic         carry;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

  function automatic vec_t mk(input string name, input logic [1:0] op, input logic [6:0] f7,
                              input logic [2:0] f3, input logic br, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [3:0] ctrl,
                              input logic [W-1:0] res, input logic ovf, input logic carry);
    vec_t v;
    v.name = name; v.op = op; v.f7 = f7; v.f3 = f3; v.br = br; v.a = a; v.b = b;
    v.ctrl = ctrl; v.res = res; v.ovf = ovf; v.carry = carry;
    return v;
  endfunction

  function automatic out_t expect_of(input vec_t v);
    out_t e;
    e.ctrl   = v.ctrl;
    e.res    = v.res;
    e.zero   = (v.res == '0);
    e.ovf    = v.ovf;
    e.r      = {v.carry, v.res};
    e.pc_src = v.br & (v.res == '0);
    return e;
  endfunction

  function automatic out_t sample();
    out_t g;
    g.ctrl = alu_ctrl; g.res = result; g.zero = zero; g.ovf = overflow; g.r = r; g.pc_src = pc_src;
    return g;
  endfunction

  task automatic report(input string name, input out_t got, input out_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got ctrl=%b result=%h zero=%b ovf=%b r=%h pc_src=%b; expected ctrl=%b result=%h zero=%b ovf=%b r=%h pc_src=%b",
               name, got.ctrl, got.res, got.zero, got.ovf, got.r, got.pc_src,
               exp.ctrl, exp.res, exp.zero, exp.ovf, exp.r, exp.pc_src);
    end
  endtask

  task automatic check_out(input string name);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
      return;
    end
    report(name, sample(), sb.pop_front());
  endtask

  task automatic drive(input vec_t v);
    alu_op = v.op; funct7 = v.f7; funct3 = v.f3; branch = v.br;
    input1 = v.a;  input2 = v.b;
    sb.push_back(expect_of(v));
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_out(v.name);
  endtask

  initial begin
    vec_t ld;
    vecs.push_back(mk("ld_addr",     2'b00, 7'h00, 3'b000, 1'b0, 64'h1000, 64'h8, 4'b0010, 64'h1008, 1'b0, 1'b0));
    vecs.push_back(mk("beq_taken",   2'b01, 7'h00, 3'b000, 1'b1, 64'd5, 64'd5, 4'b0110, 64'h0, 1'b0, 1'b1));
    vecs.push_back(mk("beq_not",     2'b01, 7'h00, 3'b000, 1'b1, 64'd5, 64'd6, 4'b0110, ONES, 1'b0, 1'b0));
    vecs.push_back(mk("and",         2'b10, 7'h00, 3'b111, 1'b0, 64'hF0F0, 64'h0FF0, 4'b0000, 64'h00F0, 1'b0, 1'b0));
    vecs.push_back(mk("or",          2'b10, 7'h00, 3'b110, 1'b0, 64'hF0F0, 64'h0FF0, 4'b0001, 64'hFFF0, 1'b0, 1'b0));
    vecs.push_back(mk("xor",         2'b10, 7'h00, 3'b100, 1'b0, 64'hF0F0, 64'h0FF0, 4'b0011, 64'hFF00, 1'b0, 1'b0));
    vecs.push_back(mk("add_ovf",     2'b10, 7'h00, 3'b000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, MSB, 1'b1, 1'b0));
    vecs.push_back(mk("sub_0m1",     2'b10, 7'h20, 3'b000, 1'b0, 64'd0, 64'd1, 4'b0110, ONES, 1'b0, 1'b0));
    vecs.push_back(mk("sub_ovf",     2'b10, 7'h20, 3'b000, 1'b0, MSB, 64'd1, 4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));
    vecs.push_back(mk("add_wrap_br", 2'b10, 7'h00, 3'b000, 1'b1, ONES, 64'd1, 4'b0010, 64'h0, 1'b0, 1'b1));
    vecs.push_back(mk("slt_m1_1",    2'b10, 7'h00, 3'b010, 1'b0, ONES, 64'd1, 4'b0111, 64'd1, 1'b0, 1'b0));
    vecs.push_back(mk("sltu_m1_1",   2'b10, 7'h00, 3'b011, 1'b0, ONES, 64'd1, 4'b1001, 64'd0, 1'b0, 1'b0));
    vecs.push_back(mk("sltu_1_m1",   2'b10, 7'h00, 3'b011, 1'b0, 64'd1, ONES, 4'b1001, 64'd1, 1'b0, 1'b0));
    vecs.push_back(mk("op11_add",    2'b11, 7'h20, 3'b111, 1'b0, 64'd3, 64'd4, 4'b0010, 64'd7, 1'b0, 1'b0));
    vecs.push_back(mk("op00_f3junk", 2'b00, 7'h20, 3'b111, 1'b0, 64'h10, 64'h20, 4'b0010, 64'h30, 1'b0, 1'b0));
`ifdef ALU_SHIFT_EN
    vecs.push_back(mk("sra",         2'b10, 7'h20, 3'b101, 1'b0, MSB, 64'd4, 4'b1000, 64'hF800_0000_0000_0000, 1'b0, 1'b0));
    vecs.push_back(mk("srl",         2'b10, 7'h00, 3'b101, 1'b0, MSB, 64'd4, 4'b0101, 64'h0800_0000_0000_0000, 1'b0, 1'b0));
    vecs.push_back(mk("sll_63",      2'b10, 7'h00, 3'b001, 1'b0, 64'd1, 64'd63, 4'b0100, MSB, 1'b0, 1'b0));
    vecs.push_back(mk("sll_mask",    2'b10, 7'h00, 3'b001, 1'b0, 64'd1, 64'h44, 4'b0100, 64'h10, 1'b0, 1'b0));
`else
    vecs.push_back(mk("sra_as_add",  2'b10, 7'h20, 3'b101, 1'b0, MSB, 64'd4, 4'b0010, 64'h8000_0000_0000_0004, 1'b0, 1'b0));
    vecs.push_back(mk("srl_as_add",  2'b10, 7'h00, 3'b101, 1'b0, MSB, 64'd4, 4'b0010, 64'h8000_0000_0000_0004, 1'b0, 1'b0));
    vecs.push_back(mk("sll_as_add",  2'b10, 7'h00, 3'b001, 1'b0, 64'd1, 64'd63, 4'b0010, 64'h40, 1'b0, 1'b0));
    vecs.push_back(mk("sll_as_add2", 2'b10, 7'h00, 3'b001, 1'b0, 64'd1, 64'h44, 4'b0010, 64'h45, 1'b0, 1'b0));
`endif

    reset = 1'b1; alu_op = '0; funct7 = '0; funct3 = '0; branch = 1'b0; input1 = '0; input2 = '0;
    repeat (2) @(posedge clk);
    #1;
    report("reset_state", sample(), '0);

    // Reset released at the same negedge the first vector is driven.
    @(negedge clk);
    reset = 1'b0;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check_out(vecs[0].name);

    for (int i = 1; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Asynchronous reset mid-stream, observed before any further clock edge.
    ld = vecs[0];
    run_vec(ld);
    #2;
    reset = 1'b1;
    #1;
    report("async_reset", sample(), '0);
    @(posedge clk);
    #1;
    report("reset_held", sample(), '0);
    @(negedge clk);
    reset = 1'b0;
    drive(vecs[3]);
    @(posedge clk);
    #1;
    check_out("first_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
